bram_pair_reader: RTL and testbench
===================================

BRAM_PAIR_READER -- requirements
Module: bram_pair_reader

Interface
REQ-001 The block SHALL have the following parameters, one per line:
- ADDR_W, default 10, BRAM address width.
- RD_LAT, default 1, BRAM read latency in cycles, range 1..3.
- ADD_LAT, default 1, latency of the downstream registered adder in cycles.

REQ-002 The block SHALL have the following ports, one per line:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a read burst; sampled only in IDLE.
- len  input  ADDR_W+1  word count for the burst, 0..2^ADDR_W; sampled with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse marking burst completion.
- ena  output  1  read enable, shared by both source BRAMs.
- addra  output  ADDR_W  read address, shared by both source BRAMs.
- sum_valid  output  1  high in each cycle the adder's registered sum holds a burst result.
- sum_addr  output  ADDR_W  source address of the result flagged by sum_valid.

Function
REQ-003 The block SHALL implement the FSM states IDLE, ISSUE, DRAIN and FIN.
REQ-004 In IDLE, start=1 with len>0 SHALL latch len, go to ISSUE and reset the address counter to 0.
REQ-005 In IDLE, start=1 with len=0 SHALL go to FIN and issue no reads.
REQ-006 In ISSUE, the block SHALL drive ena=1 and addra=k in the k-th ISSUE cycle (k=0..len-1), all outputs registered.
- If start is accepted at edge T, addr 0 SHALL appear in cycle T+1.
REQ-007 After issuing addr len-1, the FSM SHALL go to DRAIN with ena=0 and addra holding its last value.
REQ-008 DRAIN SHALL last until the valid pipeline is empty, then go to FIN.
REQ-009 FIN SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-010 For len>0, done SHALL pulse in the cycle after the final sum_valid.
REQ-011 A valid/address shift pipeline of depth RD_LAT+ADD_LAT SHALL carry (ena, addra).
- sum_valid/sum_addr for address k SHALL be high in cycle T+1+k+RD_LAT+ADD_LAT.
REQ-012 sum_valid SHALL be high for exactly len consecutive cycles per burst, with strictly increasing sum_addr and no gaps.
REQ-013 start asserted while busy=1 SHALL be ignored, with no effect on the counter, len or outputs.
REQ-014 len=2^ADDR_W SHALL read every address 0..2^ADDR_W-1 exactly once.
- The counter SHALL be ADDR_W+1 bits wide so termination never depends on address wrap-around.
REQ-015 busy SHALL be 1 in ISSUE, DRAIN and FIN, and 0 in IDLE.

Reset
REQ-016 rst=1 SHALL asynchronously force state IDLE and clear to 0: busy, done, ena, addra, sum_valid, sum_addr, the counter and every pipeline stage.
REQ-017 Reset mid-burst SHALL drop all in-flight results: no sum_valid and no done may follow until a new start is accepted.
REQ-018 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding and the default ADDR_W/RD_LAT/ADD_LAT constants.
REQ-020 The valid/address delay line SHALL be one sub-module, valid_delay_line.
- Parameters: depth and width.
- Reset: asynchronous, clearing every stage.
REQ-021 The block SHALL contain no datapath arithmetic; data flows directly from the BRAMs to the adder.

Verification
REQ-022 The bench SHALL cover these directed scenarios (defaults unless stated; T = start edge):
- len=4: ena on cycles T+1..T+4 with addra 0..3; sum_valid on T+3..T+6 with sum_addr 0..3; done at T+7; with BRAM contents A[k]=k, B[k]=10*k, sums are 0, 11, 22, 33.
- len=0: no ena and no sum_valid; done at T+1; busy high for exactly 1 cycle.
- len=1024 (ADDR_W=10): 1024 sum_valid cycles, sum_addr 0..1023 contiguous; addra never returns to 0 mid-burst.
- start re-pulsed during ISSUE of a len=8 burst: exactly 8 results and one done.
- rst asserted at T+3 of a len=8 burst: all outputs are 0 immediately; no sum_valid or done afterwards; a following len=2 burst completes normally.
- RD_LAT=3, len=2: sum_valid on T+5..T+6; done at T+7.

Source files
------------

// File: rtl/bram_pair_reader_pkg.sv
// Shared constants and FSM encoding for the BRAM pair reader.
package bram_pair_reader_pkg;

    localparam int unsigned DefAddrW  = 10;
    localparam int unsigned DefRdLat  = 1;
    localparam int unsigned DefAddLat = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StFin   = 2'd3
    } state_e;

endpackage

// File: rtl/bram_pair_reader_if.sv
// Burst request/status and shared BRAM read port of the pair reader.
interface bram_pair_reader_if
    import bram_pair_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW
);

    logic              start;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              ena;
    logic [ADDR_W-1:0] addra;
    logic              sum_valid;
    logic [ADDR_W-1:0] sum_addr;

    modport master (
        output start, len,
        input  busy, done, ena, addra, sum_valid, sum_addr
    );

    modport slave (
        input  start, len,
        output busy, done, ena, addra, sum_valid, sum_addr
    );

endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register; the MSB of each word is treated as its valid flag.
module valid_delay_line #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             pending
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

    // Valid still travelling behind the output stage: the pipe empties after this edge otherwise.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            pending = pending | stage[i][WIDTH-1];
        end
    end

endmodule

// File: rtl/bram_pair_reader.sv
// Issues a burst of shared reads to two BRAMs and tags the adder output with valid/address.
module bram_pair_reader
    import bram_pair_reader_pkg::*;
#(
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned RD_LAT  = DefRdLat,
    parameter int unsigned ADD_LAT = DefAddLat
) (
    input  logic              clk,
    input  logic              rst,
    bram_pair_reader_if.slave bus
);

    localparam int unsigned   Depth = RD_LAT + ADD_LAT;
    localparam logic [ADDR_W:0] One = 1;

    state_e          state;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] cnt;
    logic [ADDR_W:0] cnt_next;
    logic            busy_q;
    logic            done_q;
    logic            ena_q;
    logic            pending;
    logic [ADDR_W:0] dly_out;

    // One bit wider than the address so a full 2^ADDR_W burst terminates without wrap.
    assign cnt_next = cnt + One;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            len_q  <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ena_q  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.len != '0) begin
                            len_q <= bus.len;
                            cnt   <= '0;
                            ena_q <= 1'b1;
                            state <= StIssue;
                        end else begin
                            done_q <= 1'b1;
                            state  <= StFin;
                        end
                    end
                end
                StIssue: begin
                    if (cnt_next == len_q) begin
                        ena_q <= 1'b0;
                        state <= StDrain;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                StDrain: begin
                    if (!pending) begin
                        done_q <= 1'b1;
                        state  <= StFin;
                    end
                end
                StFin: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    valid_delay_line #(
        .DEPTH (Depth),
        .WIDTH (ADDR_W + 1)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .din     ({ena_q, cnt[ADDR_W-1:0]}),
        .dout    (dly_out),
        .pending (pending)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ena       = ena_q;
    assign bus.addra     = cnt[ADDR_W-1:0];
    assign bus.sum_valid = dly_out[ADDR_W];
    assign bus.sum_addr  = dly_out[ADDR_W-1:0];

endmodule

// File: tb/tb_bram_pair_reader.sv
// Self-checking bench: directed burst table, reset/latency corner cases, random bursts.
module tb_bram_pair_reader;

    localparam int unsigned AW = 10;
    localparam int D1 = 2;  // RD_LAT=1, ADD_LAT=1
    localparam int D2 = 4;  // RD_LAT=3, ADD_LAT=1

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bram_pair_reader_if #(.ADDR_W(AW)) bus1 ();
    bram_pair_reader_if #(.ADDR_W(AW)) bus2 ();

    bram_pair_reader #(.ADDR_W(AW), .RD_LAT(1), .ADD_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    bram_pair_reader #(.ADDR_W(AW), .RD_LAT(3), .ADD_LAT(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Source BRAMs plus registered adder for dut1, modelled as a D1-cycle data path.
    int mem_a [1024];
    int mem_b [1024];
    int sum_pipe [D1];

    always_ff @(posedge clk) begin
        sum_pipe[0] <= mem_a[bus1.addra] + mem_b[bus1.addra];
        for (int i = 1; i < D1; i++) sum_pipe[i] <= sum_pipe[i-1];
    end

    int checks = 0;
    int errors = 0;
    int last_addr = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Caller is at a negedge with dut1 idle. Expected per-cycle values come from the burst
    // timing rules: ena at T+1..T+L, results at T+1+k+D, done one cycle after the last result.
    task automatic run_burst(input int l, input bit repulse,
                             output int n_res, output int n_busy, output int n_done);
        int  done_rel;
        bit  exp_sv;
        int  k;
        done_rel = (l == 0) ? 1 : l + D1 + 1;
        n_res = 0;
        n_busy = 0;
        n_done = 0;
        bus1.start = 1'b1;
        bus1.len   = l[AW:0];
        @(posedge clk);
        #1 bus1.start = 1'b0;
        for (int rel = 1; rel <= done_rel + 1; rel++) begin
            @(negedge clk);
            chk("busy", int'(bus1.busy), int'(rel <= done_rel));
            chk("done", int'(bus1.done), int'(rel == done_rel));
            chk("ena", int'(bus1.ena), int'(l > 0 && rel <= l));
            if (l > 0) last_addr = (rel < l) ? rel - 1 : l - 1;
            chk("addra", int'(bus1.addra), last_addr);
            exp_sv = (l > 0) && (rel >= 1 + D1) && (rel <= l + D1);
            chk("sum_valid", int'(bus1.sum_valid), int'(exp_sv));
            if (exp_sv) begin
                k = rel - 1 - D1;
                chk("sum_addr", int'(bus1.sum_addr), k);
                chk("sum", sum_pipe[D1-1], 11 * k);
            end
            n_res  += int'(bus1.sum_valid);
            n_busy += int'(bus1.busy);
            n_done += int'(bus1.done);
            bus1.start = repulse && (rel < done_rel);
            bus1.len   = 11'd5;
        end
        bus1.start = 1'b0;
    endtask

    typedef struct {
        int len;
        bit repulse;
        int exp_res;
        int exp_busy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n_res, n_busy, n_done;
        int sv, dn, bs;
        int l, gap;
        bit rp;

        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = i;
            mem_b[i] = 10 * i;
        end

        vecs[0] = '{len: 4,    repulse: 1'b0, exp_res: 4,    exp_busy: 7};
        vecs[1] = '{len: 0,    repulse: 1'b0, exp_res: 0,    exp_busy: 1};
        vecs[2] = '{len: 1,    repulse: 1'b0, exp_res: 1,    exp_busy: 4};
        vecs[3] = '{len: 8,    repulse: 1'b1, exp_res: 8,    exp_busy: 11};
        vecs[4] = '{len: 3,    repulse: 1'b0, exp_res: 3,    exp_busy: 6};
        vecs[5] = '{len: 1024, repulse: 1'b0, exp_res: 1024, exp_busy: 1027};

        rst = 1'b1;
        bus1.start = 1'b0;
        bus1.len   = '0;
        bus2.start = 1'b0;
        bus2.len   = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", int'(bus1.busy), 0);
        chk("rst_done", int'(bus1.done), 0);
        chk("rst_ena", int'(bus1.ena), 0);
        chk("rst_addra", int'(bus1.addra), 0);
        chk("rst_sum_valid", int'(bus1.sum_valid), 0);
        chk("rst_sum_addr", int'(bus1.sum_addr), 0);

        // First burst launches on the first rising edge after reset release.
        rst = 1'b0;
        foreach (vecs[i]) begin
            run_burst(vecs[i].len, vecs[i].repulse, n_res, n_busy, n_done);
            chk($sformatf("vec%0d_results", i), n_res, vecs[i].exp_res);
            chk($sformatf("vec%0d_busy_cycles", i), n_busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_done_count", i), n_done, 1);
        end

        // Reset in the middle of a len=8 burst.
        bus1.start = 1'b1;
        bus1.len   = 11'd8;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(bus1.busy), 0);
        chk("midrst_done", int'(bus1.done), 0);
        chk("midrst_ena", int'(bus1.ena), 0);
        chk("midrst_addra", int'(bus1.addra), 0);
        chk("midrst_sum_valid", int'(bus1.sum_valid), 0);
        chk("midrst_sum_addr", int'(bus1.sum_addr), 0);
        last_addr = 0;
        @(negedge clk);
        rst = 1'b0;
        sv = 0;
        dn = 0;
        bs = 0;
        repeat (20) begin
            @(negedge clk);
            sv += int'(bus1.sum_valid);
            dn += int'(bus1.done);
            bs += int'(bus1.busy);
        end
        chk("postrst_sum_valid", sv, 0);
        chk("postrst_done", dn, 0);
        chk("postrst_busy", bs, 0);
        run_burst(2, 1'b0, n_res, n_busy, n_done);
        chk("postrst_results", n_res, 2);
        chk("postrst_done_count", n_done, 1);

        // RD_LAT=3, len=2 on the second instance.
        bus2.start = 1'b1;
        bus2.len   = 11'd2;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        for (int rel = 1; rel <= 9; rel++) begin
            @(negedge clk);
            chk("lat3_sum_valid", int'(bus2.sum_valid), int'(rel >= 1 + D2 && rel <= 2 + D2));
            chk("lat3_done", int'(bus2.done), int'(rel == 2 + D2 + 1));
            chk("lat3_busy", int'(bus2.busy), int'(rel <= 2 + D2 + 1));
            if (rel >= 1 + D2 && rel <= 2 + D2)
                chk("lat3_sum_addr", int'(bus2.sum_addr), rel - 1 - D2);
        end

        // Random bursts with random idle gaps and stray start pulses while busy.
        repeat (40) begin
            l   = int'($urandom_range(0, 24));
            rp  = 1'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            run_burst(l, rp, n_res, n_busy, n_done);
            chk("rand_results", n_res, l);
            chk("rand_done_count", n_done, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
